// File: rtl/riscv_trace_buffer_if.sv
// Signal bundle between the core's retire/debug outputs and the trace buffer.
// The master side drives capture and readout; the slave side is the buffer.
interface riscv_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 2*XLEN + 32 + 5;

  logic              arm_i;
  logic              trig_en_i;
  logic [XLEN-1:0]   trig_pc_i;
  logic              valid_i;
  logic [XLEN-1:0]   pc_i;
  logic [31:0]       instr_i;
  logic [XLEN-1:0]   result_i;
  logic [4:0]        waddr_i;
  logic [AW-1:0]     rd_idx_i;
  logic [REC_W-1:0]  rd_rec_o;
  logic [AW:0]       count_o;
  logic [1:0]        state_o;
  logic              done_o;
  logic              trig_hit_o;

  modport master (
    output arm_i, trig_en_i, trig_pc_i, valid_i, pc_i, instr_i, result_i,
           waddr_i, rd_idx_i,
    input  rd_rec_o, count_o, state_o, done_o, trig_hit_o
  );

  modport slave (
    input  arm_i, trig_en_i, trig_pc_i, valid_i, pc_i, instr_i, result_i,
           waddr_i, rd_idx_i,
    output rd_rec_o, count_o, state_o, done_o, trig_hit_o
  );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Circular retire-trace buffer: captures {pc,instr,result,waddr} records, freezes
// POST_TRIG records after a PC-match trigger, and reads back oldest-first by index.
module riscv_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input logic                  clk,
  input logic                  rst,
  riscv_trace_buffer_if.slave  tb_if
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 2*XLEN + 32 + 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    post_cnt_q, post_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             trig_hit_q, trig_hit_d;
  logic [REC_W-1:0] rd_rec_q, rd_rec_d;

  logic [REC_W-1:0] mem [DEPTH];
  logic             we;
  logic [REC_W-1:0] rec_wr;
  logic             pc_match;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    phys;
  logic [CW-1:0]    count_inc;

  assign rec_wr    = {tb_if.pc_i, tb_if.instr_i, tb_if.result_i, tb_if.waddr_i};
  assign pc_match  = tb_if.trig_en_i && (tb_if.pc_i == tb_if.trig_pc_i);
  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    post_cnt_d = post_cnt_q;
    count_d    = count_q;
    trig_hit_d = trig_hit_q;
    we         = 1'b0;

    // Arm wins over everything, including a coincident retire.
    if (tb_if.arm_i) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      trig_hit_d = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (tb_if.valid_i) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_inc;
            if (pc_match) begin
              trig_hit_d = 1'b1;
              if (POST_TRIG == 0) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_POST;
                post_cnt_d = POST_C;
              end
            end
          end
        end
        S_POST: begin
          if (tb_if.valid_i) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            count_d    = count_inc;
            post_cnt_d = post_cnt_q - CW'(1);
            if (post_cnt_q == CW'(1)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Once the buffer has wrapped, the oldest record sits at the write pointer.
  always_comb begin
    oldest   = (count_q < DEPTH_C) ? '0 : wr_ptr_q;
    phys     = oldest + tb_if.rd_idx_i;
    rd_rec_d = ({1'b0, tb_if.rd_idx_i} < count_q) ? mem[phys] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      trig_hit_q <= 1'b0;
      rd_rec_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
      trig_hit_q <= trig_hit_d;
      rd_rec_q   <= rd_rec_d;
    end
  end

  // Storage is not reset; count_q gates every readout.
  always_ff @(posedge clk) begin
    if (we && rst) mem[wr_ptr_q] <= rec_wr;
  end

  assign tb_if.rd_rec_o   = rd_rec_q;
  assign tb_if.count_o    = count_q;
  assign tb_if.state_o    = state_q;
  assign tb_if.done_o     = (state_q == S_DONE);
  assign tb_if.trig_hit_o = trig_hit_q;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer (DEPTH=8, POST_TRIG=3).
module tb_riscv_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int PT    = 3;
  localparam int REC_W = 2*XLEN + 37;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  riscv_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) tif ();

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
    .clk   (clk),
    .rst   (rst),
    .tb_if (tif)
  );

  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] pc);
    return {pc, pc ^ 32'h0000_0013, pc + 32'h1, pc[6:2]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    tif.pc_i     = pc;
    tif.instr_i  = pc ^ 32'h0000_0013;
    tif.result_i = pc + 32'h1;
    tif.waddr_i  = pc[6:2];
  endtask

  task automatic feed(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      tif.valid_i = 1'b1;
      set_pc(pc0 + 32'(4*i));
      step();
    end
    tif.valid_i = 1'b0;
  endtask

  task automatic arm();
    tif.arm_i = 1'b1;
    step();
    tif.arm_i = 1'b0;
  endtask

  task automatic read(input int idx);
    tif.rd_idx_i = 3'(idx);
    step();
  endtask

  initial begin
    tif.arm_i = 0; tif.trig_en_i = 0; tif.trig_pc_i = '0; tif.valid_i = 0;
    tif.rd_idx_i = 3'd2;
    set_pc(32'h0);
    step(); step();
    chk("rst_state", 128'(tif.state_o), 128'd0);
    chk("rst_count", 128'(tif.count_o), 128'd0);
    chk("rst_rec", 128'(tif.rd_rec_o), 128'd0);
    chk("rst_trig", 128'(tif.trig_hit_o), 128'd0);
    chk("rst_done", 128'(tif.done_o), 128'd0);
    rst = 1'b1;

    feed(32'h100, 1);
    chk("idle_ignore_cnt", 128'(tif.count_o), 128'd0);
    chk("idle_state", 128'(tif.state_o), 128'd0);

    // Basic capture
    arm();
    chk("arm_state", 128'(tif.state_o), 128'd1);
    feed(32'h0, 5);
    chk("cap5_count", 128'(tif.count_o), 128'd5);
    chk("cap5_state", 128'(tif.state_o), 128'd1);
    read(0); chk("cap5_rd0", 128'(tif.rd_rec_o), 128'(mk_rec(32'h0)));
    read(5); chk("cap5_rd5", 128'(tif.rd_rec_o), 128'd0);
    read(4); chk("cap5_rd4", 128'(tif.rd_rec_o), 128'(mk_rec(32'h10)));

    // Free-run wrap
    arm();
    feed(32'h0, 11);
    chk("wrap_count", 128'(tif.count_o), 128'd8);
    read(0); chk("wrap_rd0", 128'(tif.rd_rec_o), 128'(mk_rec(32'hC)));
    read(7); chk("wrap_rd7", 128'(tif.rd_rec_o), 128'(mk_rec(32'h28)));

    // Trigger with post-capture
    arm();
    tif.trig_en_i = 1'b1; tif.trig_pc_i = 32'h20;
    feed(32'h0, 8);
    chk("pre_trig_hit", 128'(tif.trig_hit_o), 128'd0);
    feed(32'h20, 1);
    chk("trig_hit", 128'(tif.trig_hit_o), 128'd1);
    chk("trig_state", 128'(tif.state_o), 128'd2);
    feed(32'h24, 2);
    chk("post_state", 128'(tif.state_o), 128'd2);
    chk("post_done0", 128'(tif.done_o), 128'd0);
    feed(32'h2C, 1);
    chk("done", 128'(tif.done_o), 128'd1);
    chk("done_state", 128'(tif.state_o), 128'd3);
    feed(32'h30, 2);
    chk("frozen_count", 128'(tif.count_o), 128'd8);
    read(7); chk("frozen_rd7", 128'(tif.rd_rec_o), 128'(mk_rec(32'h2C)));
    read(0); chk("frozen_rd0", 128'(tif.rd_rec_o), 128'(mk_rec(32'h10)));

    // Re-arm from DONE with a coincident retire
    tif.arm_i = 1'b1; tif.valid_i = 1'b1; set_pc(32'h40);
    step();
    tif.arm_i = 1'b0; tif.valid_i = 1'b0;
    chk("rearm_count", 128'(tif.count_o), 128'd0);
    chk("rearm_trig", 128'(tif.trig_hit_o), 128'd0);
    chk("rearm_state", 128'(tif.state_o), 128'd1);
    read(0); chk("rearm_rd0_empty", 128'(tif.rd_rec_o), 128'd0);
    tif.trig_pc_i = 32'h1000;
    feed(32'h44, 1);
    read(0); chk("rearm_rd0", 128'(tif.rd_rec_o), 128'(mk_rec(32'h44)));

    // Arm while in POST
    tif.trig_pc_i = 32'h48;
    feed(32'h48, 1);
    chk("midpost_state", 128'(tif.state_o), 128'd2);
    arm();
    chk("midpost_arm_state", 128'(tif.state_o), 128'd1);
    chk("midpost_arm_count", 128'(tif.count_o), 128'd0);
    chk("midpost_arm_trig", 128'(tif.trig_hit_o), 128'd0);

    // Same-slot read and write once full
    tif.trig_en_i = 1'b0;
    feed(32'h200, 8);
    tif.rd_idx_i = 3'd0; tif.valid_i = 1'b1; set_pc(32'h220);
    step();
    tif.valid_i = 1'b0;
    chk("rw_old", 128'(tif.rd_rec_o), 128'(mk_rec(32'h200)));
    read(7); chk("rw_new", 128'(tif.rd_rec_o), 128'(mk_rec(32'h220)));

    // Reset during POST
    arm();
    tif.trig_en_i = 1'b1; tif.trig_pc_i = 32'h300;
    feed(32'h300, 1);
    chk("rstpost_pre", 128'(tif.state_o), 128'd2);
    rst = 1'b0; tif.valid_i = 1'b1; set_pc(32'h304);
    step();
    chk("rstpost_state", 128'(tif.state_o), 128'd0);
    chk("rstpost_count", 128'(tif.count_o), 128'd0);
    chk("rstpost_rec", 128'(tif.rd_rec_o), 128'd0);
    chk("rstpost_trig", 128'(tif.trig_hit_o), 128'd0);
    rst = 1'b1;
    step(); step();
    tif.valid_i = 1'b0;
    chk("rstpost_idle_cnt", 128'(tif.count_o), 128'd0);
    chk("rstpost_idle_st", 128'(tif.state_o), 128'd0);
    read(0); chk("rstpost_rd0", 128'(tif.rd_rec_o), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
